// File: rtl/sample_reader.sv
// Reads a frame of 2^ADDR_WIDTH samples from an async-read memory and streams them to uart_tx.
// Define SAMPLE_READER_CHECKSUM_EN to append an XOR checksum byte after the frame.
module sample_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  activate,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_oe,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_active,
  input  logic                  tx_done
);

`ifdef SAMPLE_READER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, FETCH, SEND, WAIT, CSUM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, SEND, WAIT, DONE} state_t;
`endif

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
`ifdef SAMPLE_READER_CHECKSUM_EN
  logic [7:0]            csum_reg;
  logic                  csum_sent_reg;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      mem_addr      <= '0;
      mem_oe        <= 1'b0;
      tx_data       <= 8'h00;
      tx_start      <= 1'b0;
      done          <= 1'b0;
`ifdef SAMPLE_READER_CHECKSUM_EN
      csum_reg      <= 8'h00;
      csum_sent_reg <= 1'b0;
`endif
    end else if (state_reg != IDLE && !activate) begin
      // Abort wins over everything, including a tx_done arriving in the same cycle.
      state_reg <= IDLE;
      tx_start  <= 1'b0;
      done      <= 1'b0;
      mem_oe    <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (activate) begin
            addr_reg      <= '0;
            mem_addr      <= '0;
            mem_oe        <= 1'b1;
            state_reg     <= FETCH;
`ifdef SAMPLE_READER_CHECKSUM_EN
            csum_reg      <= 8'h00;
            csum_sent_reg <= 1'b0;
`endif
          end
        end
        FETCH: begin
          // mem_oe/mem_addr were registered on entry, so mem_data is valid this cycle.
          tx_data   <= mem_data[7:0];
          mem_oe    <= 1'b0;
          state_reg <= SEND;
`ifdef SAMPLE_READER_CHECKSUM_EN
          csum_reg  <= csum_reg ^ mem_data[7:0];
`endif
        end
        SEND: begin
          if (!tx_active) begin
            tx_start  <= 1'b1;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (tx_done) begin
            if (addr_reg != LAST_ADDR) begin
              addr_reg  <= addr_reg + 1'b1;
              mem_addr  <= addr_reg + 1'b1;
              mem_oe    <= 1'b1;
              state_reg <= FETCH;
            end
`ifdef SAMPLE_READER_CHECKSUM_EN
            else if (!csum_sent_reg) begin
              state_reg <= CSUM;
            end
`endif
            else begin
              done      <= 1'b1;
              state_reg <= DONE;
            end
          end
        end
`ifdef SAMPLE_READER_CHECKSUM_EN
        CSUM: begin
          tx_data       <= csum_reg;
          csum_sent_reg <= 1'b1;
          state_reg     <= SEND;
        end
`endif
        DONE: begin
          done <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_reader.sv
// Randomized self-checking bench for sample_reader: memory + uart_tx models, frame reference model.
`timescale 1ns/1ps
module tb_sample_reader;
  localparam int AW = 8;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          act_drv = 1'b0;
  logic          hold_active = 1'b0;
  logic          uart_busy = 1'b0;
  logic          tx_done = 1'b0;
  logic          done, mem_oe, tx_start;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data, tx_data;
  logic [7:0]    mem [N];
  logic [7:0]    sent_q[$];
  logic [7:0]    exp_q[$];

  int n_cmp = 0, n_bad = 0;
  int start_cnt = 0, done_pulses = 0, overlap_err = 0, uart_cnt = 0, abort_at = 0;
  bit rand_lat = 1'b0;

  wire activate  = act_drv && !(abort_at != 0 && done_pulses >= abort_at);
  wire tx_active = uart_busy | hold_active;
  assign mem_data = mem[mem_addr];

  always #10 clk = ~clk;

  sample_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .activate(activate), .done(done),
    .mem_addr(mem_addr), .mem_oe(mem_oe), .mem_data(mem_data),
    .tx_data(tx_data), .tx_start(tx_start), .tx_active(tx_active), .tx_done(tx_done)
  );

  // uart_tx model: latches the byte on tx_start, pulses tx_done after a latency
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (!reset) begin
      uart_cnt  = 0;
      uart_busy = 1'b0;
    end else begin
      if (uart_cnt > 0) begin
        uart_cnt--;
        if (uart_cnt == 0) begin
          tx_done   = 1'b1;
          uart_busy = 1'b0;
          done_pulses++;
        end
      end
      if (tx_start) begin
        if (uart_busy) overlap_err++;
        sent_q.push_back(tx_data);
        start_cnt++;
        uart_busy = 1'b1;
        uart_cnt  = rand_lat ? int'($urandom_range(12, 1)) : 10;
      end
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Reference frame: every memory byte in address order, plus XOR of all of them when enabled
  task automatic build_expected();
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(mem[i]);
`ifdef SAMPLE_READER_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < N; i++) x = x ^ mem[i];
      exp_q.push_back(x);
    end
`endif
  endtask

  task automatic run_job(input string name);
    int base_s, base_d, base_q, cyc, got_n;
    build_expected();
    base_s = start_cnt;
    base_d = done_pulses;
    base_q = sent_q.size();
    act_drv = 1'b1;
    cyc = 0;
    while (!done && cyc < 8000) begin
      step();
      cyc++;
    end
    check_value($sformatf("%s done_timeout", name), 32'(cyc < 8000), 1);
    check_value($sformatf("%s done_after_last", name), done_pulses - base_d, exp_q.size());
    check_value($sformatf("%s starts", name), start_cnt - base_s, exp_q.size());
    got_n = sent_q.size() - base_q;
    for (int i = 0; i < exp_q.size() && i < got_n; i++)
      check_value($sformatf("%s byte%0d", name, i), sent_q[base_q + i], exp_q[i]);
    step(20);
    check_value($sformatf("%s done_held", name), done, 1);
    check_value($sformatf("%s no_extra_start", name), start_cnt - base_s, exp_q.size());
    check_value($sformatf("%s mem_oe_in_done", name), mem_oe, 0);
    act_drv = 1'b0;
    step();
    check_value($sformatf("%s done_cleared", name), done, 0);
    $display("job %s: %0d bytes sent, %0d expected", name, got_n, exp_q.size());
  endtask

  initial begin
    int base_s, cyc;
    for (int i = 0; i < N; i++) mem[i] = 8'(i);

    #1 reset = 1'b0;
    #4;
    check_value("rst done", done, 0);
    check_value("rst mem_oe", mem_oe, 0);
    check_value("rst mem_addr", mem_addr, 0);
    check_value("rst tx_data", tx_data, 0);
    check_value("rst tx_start", tx_start, 0);
    step(2);
    reset = 1'b1;
    step(2);

    run_job("ramp");

    rand_lat = 1'b1;
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    run_job("random");
    rand_lat = 1'b0;

    for (int i = 0; i < N; i++) mem[i] = 8'hA5;
    run_job("all_a5");

    for (int i = 0; i < N; i++) mem[i] = 8'h00;
    mem[0] = 8'h3C;
    run_job("single_3c");

    // tx_active held high while the FSM sits in SEND
    for (int i = 0; i < N; i++) mem[i] = 8'(i);
    hold_active = 1'b1;
    base_s = start_cnt;
    act_drv = 1'b1;
    step(50);
    check_value("hold no_start", start_cnt - base_s, 0);
    check_value("hold tx_start_low", tx_start, 0);
    hold_active = 1'b0;
    step();
    check_value("hold release_pulse", tx_start, 1);
    check_value("hold release_count", start_cnt - base_s, 1);
    check_value("hold release_byte", tx_data, 8'h00);
    step();
    check_value("hold pulse_width", tx_start, 0);
    act_drv = 1'b0;
    step(15);

    // Abort coinciding with the 5th tx_done
    base_s = start_cnt;
    abort_at = done_pulses + 5;
    act_drv = 1'b1;
    cyc = 0;
    while (done_pulses < abort_at && cyc < 500) begin
      step();
      cyc++;
    end
    check_value("abort reach_5th", 32'(cyc < 500), 1);
    step();
    check_value("abort done", done, 0);
    check_value("abort tx_start", tx_start, 0);
    check_value("abort mem_oe", mem_oe, 0);
    step(30);
    check_value("abort no_more_starts", start_cnt - base_s, 5);
    act_drv = 1'b0;
    abort_at = 0;
    step();
    run_job("after_abort");

    // Asynchronous reset while waiting on byte 0x40
    base_s = start_cnt;
    act_drv = 1'b1;
    cyc = 0;
    while (start_cnt - base_s < 65 && cyc < 2000) begin
      step();
      cyc++;
    end
    check_value("areset reach_0x40", 32'(cyc < 2000), 1);
    check_value("areset pre_addr", mem_addr, 8'h40);
    #2 reset = 1'b0;
    #1;
    check_value("areset done", done, 0);
    check_value("areset mem_oe", mem_oe, 0);
    check_value("areset mem_addr", mem_addr, 0);
    check_value("areset tx_data", tx_data, 0);
    check_value("areset tx_start", tx_start, 0);
    act_drv = 1'b0;
    step(3);
    reset = 1'b1;
    step(2);
    run_job("after_reset");

    check_value("one_start_per_done", overlap_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sample_reader.md
SAMPLE_READER -- requirements
Module: sample_reader

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 8, sample memory address width; frame length N = 2^ADDR_WIDTH bytes.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 8, sample width; only 8 is supported (one UART byte per sample).
REQ-003 The module SHALL have port clk, input, 1, single system clock (50 MHz); all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 The module SHALL have port activate, input, 1, level request from the top-level state watcher; high for the whole job.
REQ-006 The module SHALL have port done, output, 1, job complete; held high until activate falls.
REQ-007 The module SHALL have port mem_addr, output, ADDR_WIDTH, read address to the sample memory.
REQ-008 The module SHALL have port mem_oe, output, 1, memory output enable; high while reading.
REQ-009 The module SHALL have port mem_data, input, DATA_WIDTH, asynchronous-read sample memory data.
REQ-010 The module SHALL have port tx_data, output, 8, byte for uart_tx, registered.
REQ-011 The module SHALL have port tx_start, output, 1, one-cycle start pulse to uart_tx.
REQ-012 The module SHALL have port tx_active, input, 1, uart_tx busy.
REQ-013 The module SHALL have port tx_done, input, 1, uart_tx one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH, SEND, WAIT, CSUM (macro only), and DONE.
REQ-015 In IDLE, if activate=1 at a clock edge, the FSM SHALL load addr=0, clear the checksum, and enter FETCH on the next cycle.
REQ-016 In FETCH, the FSM SHALL drive mem_oe=1 and mem_addr=addr, capture mem_data into tx_data at the clock edge, and enter SEND; this is one cycle.
REQ-017 In SEND, if tx_active=0, the FSM SHALL assert tx_start for exactly one cycle and enter WAIT; if tx_active=1, it SHALL hold in SEND with tx_start=0.
REQ-018 In WAIT, on tx_done=1: if addr=N-1, the FSM SHALL go to CSUM (macro on) or DONE (macro off); otherwise it SHALL set addr=addr+1 and go to FETCH; with tx_done=0 it SHALL hold in WAIT.
REQ-019 Address arithmetic SHALL be ADDR_WIDTH bits; the last-byte test SHALL compare against all-ones, and addr SHALL NOT wrap to 0 within a job.
REQ-020 Exactly N sample bytes SHALL be sent per job, in order addr 0..N-1, with at most one tx_start per tx_done.
REQ-021 In DONE, the FSM SHALL drive done=1 and tx_start=0; when activate=0 it SHALL return to IDLE with done=0 on the next cycle.
REQ-022 If activate falls in any non-IDLE state, the FSM SHALL abort to IDLE on the next edge with tx_start=0, done=0, and mem_oe=0; a byte already started in uart_tx SHALL complete and is not retracted.
REQ-023 If tx_done and an activate fall occur in the same cycle, the abort SHALL take priority.
REQ-024 A tx_done pulse received outside WAIT SHALL be ignored.
REQ-025 The mem_oe output SHALL be 0 in IDLE and DONE; mem_addr SHALL hold its last value when not reading.

Reset
REQ-026 On reset=0, the module SHALL asynchronously force state=IDLE, addr=0, mem_addr=0, mem_oe=0, tx_data=8'h00, tx_start=0, done=0, and checksum=0.
REQ-027 Reset mid-job SHALL discard progress; after release, a new activate SHALL restart from addr 0.

Configuration
REQ-028 With macro SAMPLE_READER_CHECKSUM_EN defined, the module SHALL XOR every sent sample into an 8-bit checksum.
REQ-029 With SAMPLE_READER_CHECKSUM_EN defined, after byte N-1 the CSUM state SHALL load tx_data=checksum, send it with the same SEND/WAIT handshake, then enter DONE, giving N+1 bytes per job.
REQ-030 Without SAMPLE_READER_CHECKSUM_EN, the module SHALL omit the CSUM state and checksum register and send exactly N bytes.

Verification
REQ-031 The bench SHALL cover: memory[i]=i, activate held, uart_tx model with tx_done 10 cycles after tx_start -> bytes 00..FF in order, done=1 after the 256th tx_done, exactly 256 tx_start pulses.
REQ-032 The bench SHALL cover: the same stimulus with SAMPLE_READER_CHECKSUM_EN defined -> a 257th byte 8'h00 (XOR of 00..FF), then done=1.
REQ-033 The bench SHALL cover: memory all 8'hA5 with macro on -> 256 bytes A5, then checksum 8'h00; memory[0]=8'h3C and the rest 00 -> checksum 8'h3C.
REQ-034 The bench SHALL cover: tx_active held at 1 for 50 cycles while in SEND -> no tx_start, then a single pulse the cycle after tx_active falls.
REQ-035 The bench SHALL cover: activate dropped after the 5th tx_done -> IDLE next cycle, no further tx_start, done=0; re-activation -> first byte is memory[0].
REQ-036 The bench SHALL cover: reset=0 asserted asynchronously mid-WAIT at addr=8'h40 -> all outputs at reset values immediately, with no clock required.
